// File: rtl/denoise_frame_ctrl.sv
// Frame sequencer ahead of the denoise core: joins prev/curr pixel streams in lock-step,
// aligns both to start-of-frame, checks frame geometry and latches output_mode per frame.
module denoise_frame_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic [1:0]            mode_req,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] s_prev_axis_tdata,
  input  logic                  s_prev_axis_tvalid,
  output logic                  s_prev_axis_tready,
  input  logic                  s_prev_axis_tlast,
  input  logic                  s_prev_axis_tuser,
  input  logic [DATA_WIDTH-1:0] s_curr_axis_tdata,
  input  logic                  s_curr_axis_tvalid,
  output logic                  s_curr_axis_tready,
  input  logic                  s_curr_axis_tlast,
  input  logic                  s_curr_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_prev_tdata,
  output logic [DATA_WIDTH-1:0] m_curr_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [1:0]            output_mode,
  output logic                  busy,
  output logic [FCNT_WIDTH-1:0] frame_cnt,
  output logic [2:0]            err_status
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [FCNT_WIDTH-1:0] r_fcnt;
  logic [1:0]            r_mode;
  logic [2:0]            r_err;

  logic       w_run;
  logic       w_xlast;
  logic       w_ylast;
  logic       w_first;
  logic       w_xfer;
  logic       w_frame_end;
  logic [2:0] w_err_chk;
  logic [2:0] w_err_set;
  logic       w_prev_rdy;
  logic       w_curr_rdy;
  logic       w_mvalid;

  assign w_run       = (r_state == RUN);
  assign w_xlast     = (r_x == X_LAST);
  assign w_ylast     = (r_y == Y_LAST);
  assign w_first     = (r_x == '0) && (r_y == '0);
  assign w_xfer      = w_run && s_prev_axis_tvalid && s_curr_axis_tvalid && m_axis_tready;
  assign w_frame_end = w_xfer && w_xlast && w_ylast && (w_err_set == 3'b000);

  // Input flags versus the position this beat occupies in the frame.
  assign w_err_chk[0] = (s_prev_axis_tlast != w_xlast) || (s_curr_axis_tlast != w_xlast);
  assign w_err_chk[1] = !w_first && (s_prev_axis_tuser || s_curr_axis_tuser);
  assign w_err_chk[2] = (s_prev_axis_tlast != s_curr_axis_tlast) ||
                        (s_prev_axis_tuser != s_curr_axis_tuser);
  assign w_err_set    = w_xfer ? w_err_chk : 3'b000;

  always_comb begin
    w_state_nxt = r_state;
    w_prev_rdy  = 1'b0;
    w_curr_rdy  = 1'b0;
    w_mvalid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = SYNC;
      end
      SYNC: begin
        // Drain each stream independently until its head is a start-of-frame beat.
        w_prev_rdy = !(s_prev_axis_tvalid && s_prev_axis_tuser);
        w_curr_rdy = !(s_curr_axis_tvalid && s_curr_axis_tuser);
        if (!enable)
          w_state_nxt = IDLE;
        else if (s_prev_axis_tvalid && s_prev_axis_tuser &&
                 s_curr_axis_tvalid && s_curr_axis_tuser)
          w_state_nxt = RUN;
      end
      RUN: begin
        w_mvalid   = s_prev_axis_tvalid && s_curr_axis_tvalid;
        w_prev_rdy = m_axis_tready && s_curr_axis_tvalid;
        w_curr_rdy = m_axis_tready && s_prev_axis_tvalid;
        if (w_err_set != 3'b000)
          w_state_nxt = SYNC;
        else if (w_frame_end && !enable)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_fcnt  <= '0;
      r_mode  <= 2'b00;
      r_err   <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= (err_clr ? 3'b000 : r_err) | w_err_set;
      if ((r_state == SYNC) && (w_state_nxt == RUN))
        r_mode <= mode_req;
      if (!w_run) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_xfer) begin
        if (w_err_set != 3'b000) begin
          r_x <= '0;
          r_y <= '0;
        end else if (w_xlast) begin
          r_x <= '0;
          if (w_ylast) begin
            r_y    <= '0;
            r_fcnt <= r_fcnt + 1'b1;
            r_mode <= mode_req;
          end else begin
            r_y <= r_y + 1'b1;
          end
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign s_prev_axis_tready = w_prev_rdy;
  assign s_curr_axis_tready = w_curr_rdy;
  assign m_axis_tvalid      = w_mvalid;
  assign m_prev_tdata       = w_run ? s_prev_axis_tdata : '0;
  assign m_curr_tdata       = w_run ? s_curr_axis_tdata : '0;
  assign m_axis_tlast       = w_run && w_xlast;
  assign m_axis_tuser       = w_run && w_first;
  assign output_mode        = r_mode;
  assign busy               = (r_state != IDLE);
  assign frame_cnt          = r_fcnt;
  assign err_status         = r_err;

endmodule

// File: tb/tb_denoise_frame_ctrl.sv
// Scoreboard bench for denoise_frame_ctrl on an 8x4 frame: per-stream beat queues drive the
// inputs, expected joined beats are queued at stimulus time and popped by a separate monitor.
module tb_denoise_frame_ctrl;

  logic        aclk = 1'b0;
  logic        areset, enable, err_clr;
  logic [1:0]  mode_req;
  logic [31:0] s_prev_axis_tdata, s_curr_axis_tdata;
  logic        s_prev_axis_tvalid, s_prev_axis_tready, s_prev_axis_tlast, s_prev_axis_tuser;
  logic        s_curr_axis_tvalid, s_curr_axis_tready, s_curr_axis_tlast, s_curr_axis_tuser;
  logic [31:0] m_prev_tdata, m_curr_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [1:0]  output_mode;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [2:0]  err_status;

  denoise_frame_ctrl #(.DATA_WIDTH(32), .IMG_WIDTH(8), .IMG_HEIGHT(4), .FCNT_WIDTH(16)) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .mode_req(mode_req), .err_clr(err_clr),
    .s_prev_axis_tdata(s_prev_axis_tdata), .s_prev_axis_tvalid(s_prev_axis_tvalid),
    .s_prev_axis_tready(s_prev_axis_tready), .s_prev_axis_tlast(s_prev_axis_tlast),
    .s_prev_axis_tuser(s_prev_axis_tuser),
    .s_curr_axis_tdata(s_curr_axis_tdata), .s_curr_axis_tvalid(s_curr_axis_tvalid),
    .s_curr_axis_tready(s_curr_axis_tready), .s_curr_axis_tlast(s_curr_axis_tlast),
    .s_curr_axis_tuser(s_curr_axis_tuser),
    .m_prev_tdata(m_prev_tdata), .m_curr_tdata(m_curr_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .output_mode(output_mode), .busy(busy), .frame_cnt(frame_cnt), .err_status(err_status)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {logic [31:0] d; logic l; logic u;} beat_t;
  typedef struct {logic [31:0] pd; logic [31:0] cd; logic l; logic u; logic [1:0] md; int act;} exp_t;

  beat_t pq[$];
  beat_t cq[$];
  exp_t  exq[$];
  int    checks = 0;
  int    failures = 0;
  int    n_prev = 0;
  int    n_curr = 0;
  bit    gap_en = 0;
  bit    rdy_rand = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Frame f: 32 beats per stream; optional curr tlast moved to beat clast, extra prev tuser at
  // beat puser. Only the first nexp beats are expected at the output; act fires at beat abeat.
  task automatic gen_frame(input int f, input int clast, input int puser, input int nexp,
                           input logic [1:0] md, input int abeat, input int act);
    beat_t pb, cb;
    exp_t  e;
    for (int i = 0; i < 32; i++) begin
      pb.d = {8'hA0, 8'(f), 16'(i)};
      cb.d = {8'hC0, 8'(f), 16'(i)};
      pb.l = ((i % 8) == 7);
      cb.l = (i == clast) ? 1'b1 : ((i % 8) == 7);
      pb.u = (i == 0) || (i == puser);
      cb.u = (i == 0);
      pq.push_back(pb);
      cq.push_back(cb);
      if (i < nexp) begin
        e.pd = pb.d; e.cd = cb.d; e.l = ((i % 8) == 7); e.u = (i == 0);
        e.md = md;   e.act = (i == abeat) ? act : 0;
        exq.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((pq.size() != 0 || cq.size() != 0 || exq.size() != 0) && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d_pending expected=0", name, exq.size());
    end
    repeat (3) @(posedge aclk);
    @(negedge aclk);
  endtask

  // Stream sources: handshakes sampled mid-cycle, queues advanced just after the edge.
  initial begin
    bit pf, cf;
    int cyc = 0;
    s_prev_axis_tvalid = 0; s_prev_axis_tdata = '0; s_prev_axis_tlast = 0; s_prev_axis_tuser = 0;
    s_curr_axis_tvalid = 0; s_curr_axis_tdata = '0; s_curr_axis_tlast = 0; s_curr_axis_tuser = 0;
    forever begin
      @(negedge aclk);
      pf = s_prev_axis_tvalid && s_prev_axis_tready;
      cf = s_curr_axis_tvalid && s_curr_axis_tready;
      @(posedge aclk);
      #1;
      cyc++;
      if (pf && pq.size() > 0) begin void'(pq.pop_front()); n_prev++; end
      if (cf && cq.size() > 0) begin void'(cq.pop_front()); n_curr++; end
      if (!(s_prev_axis_tvalid && !pf))
        s_prev_axis_tvalid = (pq.size() > 0) && !(gap_en && (cyc % 3 == 0));
      if (pq.size() > 0) {s_prev_axis_tdata, s_prev_axis_tlast, s_prev_axis_tuser} = pq[0];
      s_curr_axis_tvalid = (cq.size() > 0);
      if (cq.size() > 0) {s_curr_axis_tdata, s_curr_axis_tlast, s_curr_axis_tuser} = cq[0];
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every joined transfer pops one expected beat; some beats trigger a side action.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      err_clr = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat actual=%h/%h expected=none", m_prev_tdata, m_curr_tdata);
        end else begin
          e = exq.pop_front();
          if (m_prev_tdata !== e.pd || m_curr_tdata !== e.cd || m_axis_tlast !== e.l ||
              m_axis_tuser !== e.u || output_mode !== e.md) begin
            failures++;
            $display("FAIL beat actual=%h/%h/l%b/u%b/m%0d expected=%h/%h/l%b/u%b/m%0d",
                     m_prev_tdata, m_curr_tdata, m_axis_tlast, m_axis_tuser, output_mode,
                     e.pd, e.cd, e.l, e.u, e.md);
          end
          case (e.act)
            1: enable = 1'b0;
            2: err_clr = 1'b1;
            3: mode_req = 2'd2;
            default: ;
          endcase
        end
      end
    end
  end

  initial begin
    int p0, c0, n;
    beat_t g;
    areset = 1; enable = 0; mode_req = 0; err_clr = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_busy", busy, 0);
    check("rst_prev_tready", s_prev_axis_tready, 0);
    check("rst_curr_tready", s_curr_axis_tready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_err", err_status, 0);
    check("rst_mode", output_mode, 0);
    @(posedge aclk); #2;
    areset = 0;

    // Clean frame; enable dropped at beat 10, frame still completes then idles.
    mode_req = 2'd1;
    gen_frame(1, -1, -1, 32, 2'd1, 10, 1);
    enable = 1;
    wait_drain("f1");
    check("f1_fcnt", frame_cnt, 1);
    check("f1_busy", busy, 0);
    check("f1_prev_tready", s_prev_axis_tready, 0);
    check("f1_curr_tready", s_curr_axis_tready, 0);
    check("f1_mode", output_mode, 1);

    // curr leads with 5 non-SOF beats which must be discarded while prev waits.
    mode_req = 2'd0;
    for (int i = 0; i < 5; i++) begin
      g.d = 32'hDEAD_0000 + 32'(i); g.l = 0; g.u = 0;
      cq.push_back(g);
    end
    p0 = n_prev; c0 = n_curr;
    gen_frame(2, -1, -1, 32, 2'd0, -1, 0);
    @(posedge aclk); #2;
    enable = 1;
    wait_drain("f2");
    check("f2_curr_consumed", n_curr - c0, 37);
    check("f2_prev_consumed", n_prev - p0, 32);
    check("f2_fcnt", frame_cnt, 2);

    // prev gaps and random backpressure; mode_req changes mid-frame at beat 12.
    gap_en = 1; rdy_rand = 1;
    p0 = n_prev; c0 = n_curr;
    gen_frame(3, -1, -1, 32, 2'd0, 12, 3);
    wait_drain("f3");
    gap_en = 0; rdy_rand = 0;
    check("f3_prev_consumed", n_prev - p0, 32);
    check("f3_curr_consumed", n_curr - c0, 32);
    check("f3_fcnt", frame_cnt, 3);
    check("f3_mode_after", output_mode, 2);

    // curr tlast at x=5: beat 5 still passed, rest of frame discarded in SYNC.
    gen_frame(4, 5, -1, 6, 2'd2, -1, 0);
    wait_drain("f4");
    check("f4_err", err_status, 3'b101);
    check("f4_fcnt", frame_cnt, 3);
    check("f4_busy", busy, 1);
    check("f4_sync_tready", s_prev_axis_tready, 1);
    gen_frame(5, -1, -1, 32, 2'd2, -1, 0);
    wait_drain("f5");
    check("f5_fcnt", frame_cnt, 4);
    check("f5_err", err_status, 3'b101);

    // Early prev tuser at beat 3 with err_clr on the same cycle: new bits survive the clear.
    gen_frame(6, -1, 3, 4, 2'd2, 3, 2);
    wait_drain("f6");
    check("f6_err", err_status, 3'b110);
    check("f6_fcnt", frame_cnt, 4);

    // Reset in the middle of a frame.
    gen_frame(7, -1, -1, 32, 2'd2, -1, 0);
    n = 0;
    while (exq.size() > 25 && n < 500) begin @(posedge aclk); n++; end
    check("f7_progress_timeout", (n >= 500), 0);
    @(posedge aclk); #2;
    areset = 1; enable = 0;
    pq.delete(); cq.delete(); exq.delete();
    s_prev_axis_tvalid = 0; s_curr_axis_tvalid = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fcnt", frame_cnt, 0);
    check("mid_rst_err", err_status, 0);
    check("mid_rst_mode", output_mode, 0);
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    @(posedge aclk); #2;
    areset = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
